cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Sits between the instruction/data caches and the single shared `memory4c` instance, owning every access to it. Arbitrates instruction misses, data misses and data write-throughs, and streams 8-word block fills into the requesting cache. Fill addresses are pipelined into the 4-cycle memory. Replaces the cache-local fill FSM and the ad-hoc memory enable/wr logic.

## Interface
Parameters:
- `MEM_LAT`, 4: cycles from address presented (enable=1, wr=0) to `mem_data_valid` for that word
- `WORDS`, 8: 16-bit words per cache block (block = 16 bytes)

Ports:
- `clk` in 1: the design's single clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `i_miss` in 1: instruction cache miss, level, held until the fill completes
- `i_miss_addr` in 16: instruction miss byte address
- `d_miss` in 1: data cache miss, level
- `d_miss_addr` in 16: data miss byte address
- `d_wr_req` in 1: data store write-through request, level, held until `wr_ack`
- `d_wr_addr` in 16 / `d_wr_data` in 16: store address/data
- `i_stall` out 1: fetch stall
- `d_stall` out 1: memory-stage stall
- `fill_we` out 1: write `fill_data` at `fill_word_addr` into the selected cache
- `fill_sel` out 1: 0 = instruction cache, 1 = data cache
- `fill_word_addr` out 16 / `fill_data` out 16: fill word address/data
- `fill_done` out 1: one-cycle pulse with the last `fill_we`; cache writes tag/valid/LRU
- `wr_ack` out 1: one-cycle pulse, store accepted by memory
- `mem_enable` out 1, `mem_wr` out 1, `mem_addr` out 16, `mem_data_in` out 16: to memory4c
- `mem_data_out` in 16, `mem_data_valid` in 1: from memory4c

## Operation
- States: HOLD, IDLE, FILL, WRITE.
- HOLD: entered on reset. Counts MEM_LAT cycles, then enters IDLE. Swallows in-flight returns from a fill aborted by reset. No requests accepted.
- IDLE: priority `i_miss` > `d_miss` > `d_wr_req`.
  - On a miss, latch `base = addr & 16'hFFF0` and `fill_sel`, clear `issue_cnt` and `ret_cnt` (3-bit each), go to FILL.
  - On a write, go to WRITE.
- FILL, issue side: while `issue_cnt` < WORDS, drive `mem_enable=1`, `mem_wr=0`, `mem_addr = base + 2*issue_cnt`, then increment `issue_cnt`. One word per cycle, no bubbles.
- FILL, return side: on each `mem_data_valid`, drive `fill_we=1`, `fill_data = mem_data_out`, `fill_word_addr = base + 2*ret_cnt`, then increment `ret_cnt`.
  - On the 8th return, `fill_done=1` in the same cycle; next state IDLE.
  - `mem_data_valid` outside FILL is ignored.
- WRITE: one cycle. `mem_enable=1`, `mem_wr=1`, `mem_addr=d_wr_addr`, `mem_data_in=d_wr_data`, `wr_ack=1`; next state IDLE.
- Requests arriving during FILL/WRITE wait in IDLE arbitration. A data miss and a store never preempt a fill in progress.
- Stalls:
  - `i_stall = i_miss`
  - `d_stall = d_miss | (d_wr_req & ~wr_ack)`
  - Both outputs are combinational, so the pipeline freezes in the miss cycle.
- Arithmetic: addresses are 16-bit, mod 2^16. `base + 14` never carries because `base[3:0] = 0`.

## Timing
- Reset values: all outputs 0, state HOLD, counters 0.
- Miss seen in IDLE at cycle 0; FILL occupies cycles 1..MEM_LAT+8.
  - Issues in cycles 1..8.
  - Returns in cycles 1+MEM_LAT..8+MEM_LAT (5..12 at default).
  - `fill_done` in cycle 12; IDLE in cycle 13.
- Back-to-back: IDLE accepts a new request in its first cycle. i-fill then d-fill takes 2×12 + 1 = 25 cycles from the first miss.
- Store: accepted in IDLE at cycle 0, `wr_ack` in cycle 1, IDLE in cycle 2.
- Reset mid-FILL: next cycle HOLD, all outputs 0. Stale `mem_data_valid` pulses produce no `fill_we`. First acceptance at reset-release + MEM_LAT + 1.
- `i_miss` dropping mid-fill (flush): the fill still completes all 8 words.

## Structure
- Shared `cache_pkg`:
  - state enum `arb_state_t` {HOLD, IDLE, FILL, WRITE}
  - `BLOCK_MASK = 16'hFFF0`, `SEL_INSTR = 1'b0`, `SEL_DATA = 1'b1`
  - `WORDS`/`MEM_LAT` defaults
- One sub-module: `fill_counter`, a 3-bit counter with clear, increment and terminal flag, instantiated twice (issue and return).

## Test plan
- Reset, then `i_miss` with addr 16'h1236 one cycle after HOLD exits:
  - `mem_addr` 16'h1230..16'h123E on 8 consecutive cycles.
  - `fill_we` on cycles 5..12 with matching `fill_word_addr`, `fill_sel=0`.
  - `fill_done` only on cycle 12.
- `i_miss` (16'h0040) and `d_miss` (16'h8008) raised together:
  - Instruction fill (base 16'h0040) first, then data fill (base 16'h8000, `fill_sel=1`).
  - `fill_done` at cycles 12 and 25.
- `d_wr_req` (16'h2002, 16'hBEEF) during an i-fill:
  - No `mem_wr` until after `fill_done`.
  - Then one cycle of `mem_wr=1`, `mem_data_in=16'hBEEF`, plus `wr_ack`.
  - `d_stall` high throughout until the `wr_ack` cycle.
- Reset asserted at fill cycle 6:
  - Remaining returns produce no `fill_we`.
  - A new miss waits 4 HOLD cycles and then fills correctly with fresh data.
- Miss at 16'hFFFE: base 16'hFFF0, last issued address 16'hFFFE, no wrap into 16'h0000.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache/memory arbiter slice.
package cache_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        IDLE  = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } arb_state_t;

    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
    localparam logic        SEL_INSTR   = 1'b0;
    localparam logic        SEL_DATA    = 1'b1;
    localparam int          DEF_WORDS   = 8;
    localparam int          DEF_MEM_LAT = 4;

    // Byte address of word idx inside the block at base; base[3:0] is zero so no carry out.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] idx);
        return base + {12'h000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_fill_counter.sv
// 3-bit word counter for block fills: clear, increment, terminal flag at the last word.
module fill_counter
    import cache_pkg::*;
#(
    parameter int WORDS = DEF_WORDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] cnt,
    output logic       term
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 3'd0;
        end else if (inc) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == 3'(WORDS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Owns the shared memory4c port: arbitrates I/D misses and D write-throughs, streams block fills.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int WORDS   = DEF_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        i_stall,
    output logic        d_stall,
    output logic        fill_we,
    output logic        fill_sel,
    output logic [15:0] fill_word_addr,
    output logic [15:0] fill_data,
    output logic        fill_done,
    output logic        wr_ack,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid
);

    localparam int HOLD_W = $clog2(MEM_LAT) + 1;

    arb_state_t        state_q, state_d;
    logic [15:0]       base_q, base_d;
    logic              sel_q, sel_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              issue_done_q, issue_done_d;

    logic       iss_clr, iss_inc, iss_term;
    logic       ret_clr, ret_inc, ret_term;
    logic [2:0] iss_cnt, ret_cnt;

    fill_counter #(.WORDS(WORDS)) u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (iss_clr),
        .inc  (iss_inc),
        .cnt  (iss_cnt),
        .term (iss_term)
    );

    fill_counter #(.WORDS(WORDS)) u_ret_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (ret_clr),
        .inc  (ret_inc),
        .cnt  (ret_cnt),
        .term (ret_term)
    );

    // Next-state and output decode; fill issue and return sides run independently.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        sel_d          = sel_q;
        hold_d         = hold_q;
        issue_done_d   = issue_done_q;
        iss_clr        = 1'b0;
        iss_inc        = 1'b0;
        ret_clr        = 1'b0;
        ret_inc        = 1'b0;
        fill_we        = 1'b0;
        fill_sel       = 1'b0;
        fill_word_addr = 16'h0000;
        fill_data      = 16'h0000;
        fill_done      = 1'b0;
        wr_ack         = 1'b0;
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = 16'h0000;
        mem_data_in    = 16'h0000;

        case (state_q)
            HOLD: begin
                // Long enough for every read issued before reset to drain.
                if (hold_q == HOLD_W'(MEM_LAT - 1)) begin
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            IDLE: begin
                if (i_miss) begin
                    base_d       = i_miss_addr & BLOCK_MASK;
                    sel_d        = SEL_INSTR;
                    iss_clr      = 1'b1;
                    ret_clr      = 1'b1;
                    issue_done_d = 1'b0;
                    state_d      = FILL;
                end else if (d_miss) begin
                    base_d       = d_miss_addr & BLOCK_MASK;
                    sel_d        = SEL_DATA;
                    iss_clr      = 1'b1;
                    ret_clr      = 1'b1;
                    issue_done_d = 1'b0;
                    state_d      = FILL;
                end else if (d_wr_req) begin
                    state_d      = WRITE;
                end else begin
                    state_d      = IDLE;
                end
            end
            FILL: begin
                fill_sel = sel_q;
                if (!issue_done_q) begin
                    mem_enable = 1'b1;
                    mem_addr   = word_addr(base_q, iss_cnt);
                    iss_inc    = 1'b1;
                    if (iss_term) begin
                        issue_done_d = 1'b1;
                    end else begin
                        issue_done_d = 1'b0;
                    end
                end else begin
                    iss_inc = 1'b0;
                end
                if (mem_data_valid) begin
                    fill_we        = 1'b1;
                    fill_data      = mem_data_out;
                    fill_word_addr = word_addr(base_q, ret_cnt);
                    ret_inc        = 1'b1;
                    if (ret_term) begin
                        fill_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = FILL;
                    end
                end else begin
                    ret_inc = 1'b0;
                end
            end
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_wr_addr;
                mem_data_in = d_wr_data;
                wr_ack      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // State and fill context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HOLD;
            base_q       <= 16'h0000;
            sel_q        <= SEL_INSTR;
            hold_q       <= '0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            sel_q        <= sel_d;
            hold_q       <= hold_d;
            issue_done_q <= issue_done_d;
        end
    end

    // Stalls are combinational so the pipeline freezes in the miss cycle itself.
    assign i_stall = i_miss;
    assign d_stall = d_miss | (d_wr_req & ~wr_ack);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle pipelined read-memory model.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        i_stall, d_stall, fill_we, fill_sel, fill_done, wr_ack;
    logic [15:0] fill_word_addr, fill_data;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_data_valid;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    cache_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .i_stall        (i_stall),
        .d_stall        (d_stall),
        .fill_we        (fill_we),
        .fill_sel       (fill_sel),
        .fill_word_addr (fill_word_addr),
        .fill_data      (fill_data),
        .fill_done      (fill_done),
        .wr_ack         (wr_ack),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed pattern of the word address.
    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] wa(input logic [15:0] base, input int idx);
        return base + 16'(2 * idx);
    endfunction

    // Read pipeline: address presented in cycle N returns in cycle N+4; not reset, like the real part.
    logic [3:0]  vpipe = 4'b0000;
    logic [15:0] d0 = 16'h0000, d1 = 16'h0000, d2 = 16'h0000, d3 = 16'h0000;
    always @(posedge clk) begin
        vpipe <= {vpipe[2:0], mem_enable & ~mem_wr};
        d0    <= pat(mem_addr);
        d1    <= d0;
        d2    <= d1;
        d3    <= d2;
    end
    assign mem_data_valid = vpipe[3];
    assign mem_data_out   = d3;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at cycle rel of a fill accepted at rel 0.
    task automatic check_cycle(input int rel, input logic [15:0] base, input logic sel);
        logic en, we;
        en = (rel >= 1) && (rel <= 8);
        we = (rel >= 5) && (rel <= 12);
        chk("mem_enable", {15'd0, mem_enable}, {15'd0, en});
        chk("mem_wr", {15'd0, mem_wr}, 16'h0000);
        if (en) chk("mem_addr", mem_addr, wa(base, rel - 1));
        chk("fill_we", {15'd0, fill_we}, {15'd0, we});
        if (we) begin
            chk("fill_word_addr", fill_word_addr, wa(base, rel - 5));
            chk("fill_data", fill_data, pat(wa(base, rel - 5)));
            chk("fill_sel", {15'd0, fill_sel}, {15'd0, sel});
        end
        chk("fill_done", {15'd0, fill_done}, {15'd0, rel == 12});
    endtask

    initial begin
        rst = 1'b1;
        i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = 16'h0000; d_miss_addr = 16'h0000;
        d_wr_addr = 16'h0000; d_wr_data = 16'h0000;

        // Reset state
        tick();
        tick();
        chk("rst_mem_enable", {15'd0, mem_enable}, 16'h0000);
        chk("rst_mem_wr", {15'd0, mem_wr}, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_data_in", mem_data_in, 16'h0000);
        chk("rst_fill_we", {15'd0, fill_we}, 16'h0000);
        chk("rst_fill_sel", {15'd0, fill_sel}, 16'h0000);
        chk("rst_fill_word_addr", fill_word_addr, 16'h0000);
        chk("rst_fill_data", fill_data, 16'h0000);
        chk("rst_fill_done", {15'd0, fill_done}, 16'h0000);
        chk("rst_wr_ack", {15'd0, wr_ack}, 16'h0000);
        chk("rst_i_stall", {15'd0, i_stall}, 16'h0000);
        chk("rst_d_stall", {15'd0, d_stall}, 16'h0000);

        // Release reset; a miss raised during HOLD waits the 4 HOLD cycles
        rst = 1'b0;
        i_miss = 1'b1;
        i_miss_addr = 16'h1236;
        #1;
        chk("hold_i_stall", {15'd0, i_stall}, 16'h0001);
        for (int h = 0; h < 4; h++) begin
            if (h > 0) tick();
            chk("hold_mem_enable", {15'd0, mem_enable}, 16'h0000);
        end

        // Test 1: instruction fill of block 0x1230
        tick();
        check_cycle(0, 16'h1230, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 13) i_miss = 1'b0;
            #1;
            check_cycle(c, 16'h1230, 1'b0);
        end

        // Test 2: simultaneous I and D miss, instruction first
        i_miss = 1'b1; i_miss_addr = 16'h0040;
        d_miss = 1'b1; d_miss_addr = 16'h8008;
        #1;
        check_cycle(0, 16'h0040, 1'b0);
        chk("t2_d_stall", {15'd0, d_stall}, 16'h0001);
        for (int c = 1; c <= 26; c++) begin
            tick();
            if (c == 13) i_miss = 1'b0;
            if (c == 26) d_miss = 1'b0;
            #1;
            if (c <= 13) check_cycle(c, 16'h0040, 1'b0);
            else         check_cycle(c - 13, 16'h8000, 1'b1);
        end

        // Test 3: store raised during an instruction fill waits for it
        i_miss = 1'b1; i_miss_addr = 16'h0100;
        #1;
        check_cycle(0, 16'h0100, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 3) begin
                d_wr_req = 1'b1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;
            end
            if (c == 13) i_miss = 1'b0;
            if (c == 15) d_wr_req = 1'b0;
            #1;
            if (c <= 13) check_cycle(c, 16'h0100, 1'b0);
            else         chk("t3_mem_wr", {15'd0, mem_wr}, {15'd0, c == 14});
            chk("t3_wr_ack", {15'd0, wr_ack}, {15'd0, c == 14});
            chk("t3_d_stall", {15'd0, d_stall}, {15'd0, (c >= 3) && (c <= 13)});
            if (c == 14) begin
                chk("t3_mem_enable", {15'd0, mem_enable}, 16'h0001);
                chk("t3_mem_addr", mem_addr, 16'h2002);
                chk("t3_mem_data_in", mem_data_in, 16'hBEEF);
            end
            if (c == 15) chk("t3_idle_enable", {15'd0, mem_enable}, 16'h0000);
        end

        // Test 4: reset at fill cycle 6, stale returns swallowed, fresh fill after HOLD
        i_miss = 1'b1; i_miss_addr = 16'h2000;
        #1;
        check_cycle(0, 16'h2000, 1'b0);
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 6) begin rst = 1'b1; i_miss = 1'b0; end
            if (c == 7) rst = 1'b0;
            if (c == 8) begin i_miss = 1'b1; i_miss_addr = 16'h3006; end
            if (c == 24) i_miss = 1'b0;
            #1;
            if (c <= 6) begin
                check_cycle(c, 16'h2000, 1'b0);
            end else if (c <= 10) begin
                chk("t4_hold_fill_we", {15'd0, fill_we}, 16'h0000);
                chk("t4_hold_mem_enable", {15'd0, mem_enable}, 16'h0000);
                chk("t4_hold_fill_done", {15'd0, fill_done}, 16'h0000);
                chk("t4_hold_fill_word_addr", fill_word_addr, 16'h0000);
            end else begin
                check_cycle(c - 11, 16'h3000, 1'b0);
            end
        end

        // Test 5: top-of-memory block, miss dropped mid-fill still completes
        d_miss = 1'b1; d_miss_addr = 16'hFFFE;
        #1;
        check_cycle(0, 16'hFFF0, 1'b1);
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 3) d_miss = 1'b0;
            #1;
            if (c <= 13) check_cycle(c, 16'hFFF0, 1'b1);
            else         chk("t5_idle_enable", {15'd0, mem_enable}, 16'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
